// File: rtl/decode_pipe.sv
// Decode stage: F/D register, register file with PC alias, source select, immediate extend, registered D/E boundary.
// Optional same-cycle write-through bypass enabled by defining DECODE_BYPASS_EN.
module decode_pipe #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           InstrF,
    input  logic [WIDTH-1:0]           PCF,
    input  logic                       ValidF,
    input  logic                       StallD,
    input  logic                       FlushD,
    input  logic                       FlushE,
    input  logic [1:0]                 RegSrcD,
    input  logic [1:0]                 ImmSrcD,
    input  logic                       RegWriteW,
    input  logic [$clog2(NREGS)-1:0]   WA3W,
    input  logic [WIDTH-1:0]           ResultW,
    output logic [WIDTH-1:0]           InstrD,
    output logic                       ValidE,
    output logic [WIDTH-1:0]           RD1E,
    output logic [WIDTH-1:0]           RD2E,
    output logic [WIDTH-1:0]           ExtImmE,
    output logic [$clog2(NREGS)-1:0]   RA1E,
    output logic [$clog2(NREGS)-1:0]   RA2E,
    output logic [$clog2(NREGS)-1:0]   WA3E,
    output logic [WIDTH-1:0]           PCPlus8E
);

    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] PCIDX = AW'(NREGS - 1);

    logic [WIDTH-1:0] pcd;
    logic             validd;

    logic [AW-1:0]    ra1d;
    logic [AW-1:0]    ra2d;
    logic [AW-1:0]    wa3d;
    logic [WIDTH-1:0] pc8d;
    logic [WIDTH-1:0] rd1d;
    logic [WIDTH-1:0] rd2d;
    logic [WIDTH-1:0] immd;
    logic             hit1;
    logic             hit2;
    logic             bubble;
    logic             wr_en;

    // The top index aliases the PC, so only entries 0..NREGS-2 are ever written.
    logic [WIDTH-1:0] rf [NREGS];

    function automatic logic [AW-1:0] reg_field(input logic [3:0] f);
        return AW'(f);
    endfunction

    function automatic logic [WIDTH-1:0] ext_imm(input logic [WIDTH-1:0] instr,
                                                 input logic [1:0]       src);
        logic signed [WIDTH-1:0] se;
        se = {{(WIDTH-24){instr[23]}}, instr[23:0]};
        case (src)
            2'b00:   return {{(WIDTH-8){1'b0}}, instr[7:0]};
            2'b01:   return {{(WIDTH-12){1'b0}}, instr[11:0]};
            2'b10:   return se <<< 2;
            default: return '0;
        endcase
    endfunction

    // F/D boundary
    always_ff @(posedge clk) begin
        if (!reset) begin
            InstrD <= '0;
            pcd    <= '0;
            validd <= 1'b0;
        end else if (FlushD) begin
            InstrD <= '0;
            pcd    <= '0;
            validd <= 1'b0;
        end else if (!StallD) begin
            InstrD <= InstrF;
            pcd    <= PCF;
            validd <= ValidF;
        end
    end

    assign wr_en = RegWriteW && (WA3W != PCIDX);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREGS - 1; i++) begin
                rf[i] <= '0;
            end
        end else if (wr_en) begin
            rf[WA3W] <= ResultW;
        end
    end

    always_comb begin
        ra1d   = RegSrcD[0] ? PCIDX : reg_field(InstrD[19:16]);
        ra2d   = RegSrcD[1] ? reg_field(InstrD[15:12]) : reg_field(InstrD[3:0]);
        wa3d   = reg_field(InstrD[15:12]);
        pc8d   = pcd + WIDTH'(8);
        immd   = ext_imm(InstrD, ImmSrcD);
        bubble = FlushE || StallD || !validd;
`ifdef DECODE_BYPASS_EN
        hit1   = wr_en && (WA3W == ra1d);
        hit2   = wr_en && (WA3W == ra2d);
`else
        hit1   = 1'b0;
        hit2   = 1'b0;
`endif
        rd1d   = (ra1d == PCIDX) ? pc8d : (hit1 ? ResultW : rf[ra1d]);
        rd2d   = (ra2d == PCIDX) ? pc8d : (hit2 ? ResultW : rf[ra2d]);
    end

    // D/E boundary; a stall or an invalid D slot drops a bubble into E
    always_ff @(posedge clk) begin
        if (!reset || bubble) begin
            ValidE   <= 1'b0;
            RD1E     <= '0;
            RD2E     <= '0;
            ExtImmE  <= '0;
            RA1E     <= '0;
            RA2E     <= '0;
            WA3E     <= '0;
            PCPlus8E <= '0;
        end else begin
            ValidE   <= 1'b1;
            RD1E     <= rd1d;
            RD2E     <= rd2d;
            ExtImmE  <= immd;
            RA1E     <= ra1d;
            RA2E     <= ra2d;
            WA3E     <= wa3d;
            PCPlus8E <= pc8d;
        end
    end

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: behavioural model compared every cycle plus hand-computed literals.
module tb_decode_pipe;

    logic        clk;
    logic        reset;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic        ValidF;
    logic        StallD;
    logic        FlushD;
    logic        FlushE;
    logic [1:0]  RegSrcD;
    logic [1:0]  ImmSrcD;
    logic        RegWriteW;
    logic [3:0]  WA3W;
    logic [31:0] ResultW;
    logic [31:0] InstrD;
    logic        ValidE;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] ExtImmE;
    logic [3:0]  RA1E;
    logic [3:0]  RA2E;
    logic [3:0]  WA3E;
    logic [31:0] PCPlus8E;

`ifdef DECODE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    decode_pipe #(.WIDTH(32), .NREGS(16)) dut (
        .clk(clk), .reset(reset), .InstrF(InstrF), .PCF(PCF), .ValidF(ValidF),
        .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE), .RegSrcD(RegSrcD),
        .ImmSrcD(ImmSrcD), .RegWriteW(RegWriteW), .WA3W(WA3W), .ResultW(ResultW),
        .InstrD(InstrD), .ValidE(ValidE), .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE),
        .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E), .PCPlus8E(PCPlus8E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model
    logic [31:0] mInstrD, mPCD;
    logic        mValidD;
    logic [31:0] mrf [16];
    logic        eValid;
    logic [31:0] eRD1, eRD2, eImm, ePC8;
    logic [3:0]  eRA1, eRA2, eWA3;
    logic [3:0]  ra1, ra2;
    logic [31:0] v1, v2, imm;
    longint      s;
    bit          started = 1'b0;

    function automatic logic [31:0] rdval(input logic [3:0] a);
        if (a == 4'd15) return mPCD + 32'd8;
        if (BYP && RegWriteW && WA3W == a) return ResultW;
        return mrf[a];
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            mInstrD = 0; mPCD = 0; mValidD = 0;
            for (int i = 0; i < 16; i++) mrf[i] = 0;
            eValid = 0; eRD1 = 0; eRD2 = 0; eImm = 0; ePC8 = 0; eRA1 = 0; eRA2 = 0; eWA3 = 0;
        end else begin
            ra1 = RegSrcD[0] ? 4'd15 : mInstrD[19:16];
            ra2 = RegSrcD[1] ? mInstrD[15:12] : mInstrD[3:0];
            v1 = rdval(ra1);
            v2 = rdval(ra2);
            case (ImmSrcD)
                2'd0: imm = mInstrD & 32'hFF;
                2'd1: imm = mInstrD & 32'hFFF;
                2'd2: begin
                    s = longint'(mInstrD[23:0]);
                    if (s >= 2**23) s = s - 2**24;
                    imm = 32'(s * 4);
                end
                default: imm = 0;
            endcase
            if (FlushE || StallD || !mValidD) begin
                eValid = 0; eRD1 = 0; eRD2 = 0; eImm = 0; ePC8 = 0; eRA1 = 0; eRA2 = 0; eWA3 = 0;
            end else begin
                eValid = 1; eRD1 = v1; eRD2 = v2; eImm = imm; ePC8 = mPCD + 32'd8;
                eRA1 = ra1; eRA2 = ra2; eWA3 = mInstrD[15:12];
            end
            if (RegWriteW && WA3W != 4'd15) mrf[WA3W] = ResultW;
            if (FlushD) begin
                mInstrD = 0; mPCD = 0; mValidD = 0;
            end else if (!StallD) begin
                mInstrD = InstrF; mPCD = PCF; mValidD = ValidF;
            end
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("InstrD", InstrD, mInstrD);
            chk("ValidE", 32'(ValidE), 32'(eValid));
            chk("RD1E", RD1E, eRD1);
            chk("RD2E", RD2E, eRD2);
            chk("ExtImmE", ExtImmE, eImm);
            chk("RA1E", 32'(RA1E), 32'(eRA1));
            chk("RA2E", 32'(RA2E), 32'(eRA2));
            chk("WA3E", 32'(WA3E), 32'(eWA3));
            chk("PCPlus8E", PCPlus8E, ePC8);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] ins, input logic [31:0] pc);
        ValidF = 1'b1; InstrF = ins; PCF = pc;
    endtask

    initial begin
        reset = 0; InstrF = 32'hE0821003; PCF = 0; ValidF = 1;
        StallD = 0; FlushD = 0; FlushE = 0; RegSrcD = 0; ImmSrcD = 0;
        RegWriteW = 0; WA3W = 0; ResultW = 0;

        // reset held two edges
        tick(); tick();
        chk("rst_InstrD", InstrD, 32'h0);
        chk("rst_ValidE", 32'(ValidE), 32'h0);
        chk("rst_RD1E", RD1E, 32'h0);
        chk("rst_RD2E", RD2E, 32'h0);

        reset = 1;
        tick();
        chk("rel_InstrD", InstrD, 32'hE0821003);
        chk("rel_ValidE_early", 32'(ValidE), 32'h0);
        ValidF = 0;
        tick();
        chk("rel_ValidE", 32'(ValidE), 32'h1);
        chk("rel_RA1E", 32'(RA1E), 32'h2);
        chk("rel_RA2E", 32'(RA2E), 32'h3);
        chk("rel_WA3E", 32'(WA3E), 32'h1);

        // write then read
        RegWriteW = 1; WA3W = 2; ResultW = 32'h11;
        tick();
        WA3W = 3; ResultW = 32'h22; fetch(32'hE0821003, 32'h20);
        tick();
        RegWriteW = 0; ValidF = 0;
        tick();
        chk("wr_RD1E", RD1E, 32'h11);
        chk("wr_RD2E", RD2E, 32'h22);
        chk("wr_PC8", PCPlus8E, 32'h28);

        // same-cycle write vs read
        RegWriteW = 1; WA3W = 5; ResultW = 32'h5; fetch(32'hE0850000, 32'h40);
        tick();
        ResultW = 32'hAB; ValidF = 0;
        tick();
        chk("byp_RD1E", RD1E, BYP ? 32'hAB : 32'h5);
        RegWriteW = 0;
        fetch(32'hE0850000, 32'h44);
        tick();
        ValidF = 0;
        tick();
        chk("byp_after_RD1E", RD1E, 32'hAB);

        // PC alias read, writes to R15 discarded
        fetch(32'hE0821003, 32'h100);
        tick();
        ValidF = 0; RegSrcD = 2'b01; RegWriteW = 1; WA3W = 15; ResultW = 32'hDEAD;
        tick();
        chk("pc_RD1E", RD1E, 32'h108);
        chk("pc_RA1E", 32'(RA1E), 32'hF);
        RegWriteW = 0; RegSrcD = 0; fetch(32'hE0821003, 32'h100);
        tick();
        ValidF = 0; RegSrcD = 2'b01;
        tick();
        chk("pc_reread", RD1E, 32'h108);

        // immediates
        RegSrcD = 0; fetch(32'hE0FFFFFE, 32'h200);
        tick();
        fetch(32'hE0000FFF, 32'h204); ImmSrcD = 2; RegSrcD = 2'b10;
        tick();
        chk("imm10", ExtImmE, 32'hFFFFFFF8);
        fetch(32'hE00000AB, 32'h208); ImmSrcD = 1; RegSrcD = 0;
        tick();
        chk("imm01", ExtImmE, 32'h00000FFF);
        fetch(32'hE00012CD, 32'h20C); ImmSrcD = 3;
        tick();
        chk("imm11", ExtImmE, 32'h0);
        chk("imm11_valid", 32'(ValidE), 32'h1);
        ValidF = 0; ImmSrcD = 0;
        tick();
        chk("imm00", ExtImmE, 32'hCD);

        // stall two cycles
        fetch(32'hE0821003, 32'h300);
        tick();
        fetch(32'hE0431004, 32'h304); StallD = 1;
        tick();
        chk("stall1_InstrD", InstrD, 32'hE0821003);
        chk("stall1_ValidE", 32'(ValidE), 32'h0);
        tick();
        chk("stall2_InstrD", InstrD, 32'hE0821003);
        chk("stall2_ValidE", 32'(ValidE), 32'h0);
        StallD = 0;
        tick();
        chk("unstall_ValidE", 32'(ValidE), 32'h1);
        chk("unstall_PC8", PCPlus8E, 32'h308);
        ValidF = 0;
        tick();
        chk("next_PC8", PCPlus8E, 32'h30C);

        // StallD with FlushD: flush wins
        fetch(32'hE0821003, 32'h400);
        tick();
        StallD = 1; FlushD = 1;
        tick();
        chk("sf_InstrD", InstrD, 32'h0);
        StallD = 0; FlushD = 0; ValidF = 0;
        tick();
        chk("sf_ValidE", 32'(ValidE), 32'h0);

        // FlushE
        fetch(32'hE0821003, 32'h500);
        tick();
        ValidF = 0; FlushE = 1;
        tick();
        chk("flushE_ValidE", 32'(ValidE), 32'h0);
        FlushE = 0;

        // mid-stream reset clears pipeline and register file
        fetch(32'hE0821003, 32'h600);
        tick();
        reset = 0;
        tick();
        chk("mrst_InstrD", InstrD, 32'h0);
        chk("mrst_ValidE", 32'(ValidE), 32'h0);
        reset = 1; ValidF = 0;
        tick();
        chk("mrst_ValidE2", 32'(ValidE), 32'h0);
        fetch(32'hE0821003, 32'h700);
        tick();
        ValidF = 0;
        tick();
        chk("mrst_RD1E", RD1E, 32'h0);
        chk("mrst_RD2E", RD2E, 32'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
